// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose:
//   Shares a single SRAM-like memory port between the instruction-fetch
//   requester and the data (load/store) requester. One transaction is in
//   flight at a time. Data accesses win arbitration, except that after
//   STARVE_MAX consecutive data grants taken while a fetch was waiting, the
//   next grant goes to the fetch. Per-requester stall requests are produced
//   for the pipeline controller.
//
// Handshakes (one place, all of them):
//   * Requester side: inst_req / data_req are levels. A requester raises req
//     together with its address (and wen/wdata) and holds all of them until
//     it sees its done pulse. done is a registered one-cycle pulse; the
//     matching rdata register is valid in that cycle and holds afterwards.
//   * Memory side: mem_req is the address-phase valid and mem_addr_ok is its
//     ready. The address phase completes in the cycle both are high. The
//     data phase completes in the cycle mem_data_ok is high (mem_rdata valid
//     then). mem_data_ok may arrive in the same cycle as mem_addr_ok.
//     Responses outside the states that expect them are ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_req/inst_addr       fetch request (level) and address
//   inst_rdata/inst_done     fetched word and its completion pulse
//   data_req/data_wen/...    load/store request, byte enables (0 = load),
//                            address, store data
//   data_rdata/data_done     load result and its completion pulse
//   stallreq_inst/_data      req & ~done, for the pipeline controller
//   mem_req/mem_wr/...       memory address phase and latched attributes
//   mem_addr_ok/mem_data_ok  memory address-accept / data-complete
//   mem_rdata                memory read data
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,

  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,

  output logic        stallreq_inst,
  output logic        stallreq_data,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // owner encoding: 0 = instruction fetch, 1 = data access
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t     state;
  logic       owner;
  logic [3:0] starve_cnt;

  logic grant_data;
  logic grant_inst;
  logic complete;

  // Arbitration is evaluated every cycle but only acted on in IDLE.
  // A waiting fetch overrides data once the starvation counter saturates.
  always_comb begin
    grant_data = data_req && !(inst_req && (starve_cnt == STARVE_LIM));
    grant_inst = inst_req && !grant_data;
  end

  // The access finishes either in REQ (address and data accepted in the same
  // cycle, WAIT is skipped) or in WAIT on data_ok.
  always_comb begin
    complete = 1'b0;
    if (state == REQ && mem_addr_ok && mem_data_ok) complete = 1'b1;
    if (state == WAIT && mem_data_ok)               complete = 1'b1;
  end

  // Stall is released in the done cycle so the pipeline advances on that edge.
  assign stallreq_inst = inst_req & ~inst_done;
  assign stallreq_data = data_req & ~data_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      starve_cnt <= 4'd0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      // Done outputs are single-cycle pulses unless re-armed below.
      inst_done <= 1'b0;
      data_done <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_data || grant_inst) begin
            mem_req <= 1'b1;
            state   <= REQ;
            if (grant_data) begin
              owner     <= OWNER_DATA;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
              mem_wr    <= (data_wen != 4'd0);
              mem_wstrb <= (data_wen != 4'd0) ? data_wen : 4'hF;
              // Count data grants only while a fetch is actually waiting.
              if (inst_req) begin
                if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
              end else begin
                starve_cnt <= 4'd0;
              end
            end else begin
              owner      <= OWNER_INST;
              mem_addr   <= inst_addr;
              mem_wdata  <= 32'd0;
              mem_wr     <= 1'b0;
              mem_wstrb  <= 4'hF;
              starve_cnt <= 4'd0;
            end
          end
        end

        REQ: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= mem_data_ok ? DONE : WAIT;
          end
        end

        WAIT: begin
          if (mem_data_ok) state <= DONE;
        end

        // The requester still holds req during DONE, so no grant here.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Completion: pulse the owner's done and capture read data. Stores
      // leave data_rdata untouched; fetches are always reads.
      if (complete) begin
        if (owner == OWNER_INST) begin
          inst_done  <= 1'b1;
          inst_rdata <= mem_rdata;
        end else begin
          data_done <= 1'b1;
          if (!mem_wr) data_rdata <= mem_rdata;
        end
      end
    end
  end

  // Structural invariants of the port.
  a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(inst_done && data_done));
  a_req_only_in_req: assert property (@(posedge clk) disable iff (rst)
    mem_req == (state == REQ));
  a_done_only_in_done: assert property (@(posedge clk) disable iff (rst)
    (inst_done || data_done) == (state == DONE));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled 1 unit later, well clear of the edge.
// A small memory responder answers zero-wait with a data word derived from
// the address, used for the arbitration sequence.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        stallreq_inst;
  logic        stallreq_data;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // responder state
  logic        wait_data;
  logic [31:0] resp_addr;

  // bookkeeping
  int   req_cycles;
  int   done_cycles;
  int   done_at;
  int   n_done;
  logic seq     [10];
  logic exp_seq [10];

  sram_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_done     (inst_done),
    .data_req      (data_req),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_done     (data_done),
    .stallreq_inst (stallreq_inst),
    .stallreq_data (stallreq_data),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_wstrb     (mem_wstrb),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic mem_drive(input logic aok, input logic dok, input logic [31:0] rd);
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Zero-wait memory: accept the address the cycle mem_req is seen, return
  // data the following cycle.
  task automatic mem_auto();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (mem_req) begin
      mem_addr_ok = 1'b1;
      resp_addr   = mem_addr;
      wait_data   = 1'b1;
    end else if (wait_data) begin
      mem_data_ok = 1'b1;
      mem_rdata   = mem_word(resp_addr);
      wait_data   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wen   = 4'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    wait_data  = 1'b0;
    resp_addr  = 32'd0;
    mem_drive(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),       32'd0);
    check({tag, "_mem_wr"},     32'(mem_wr),        32'd0);
    check({tag, "_mem_wstrb"},  32'(mem_wstrb),     32'd0);
    check({tag, "_mem_addr"},   mem_addr,           32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,          32'd0);
    check({tag, "_inst_done"},  32'(inst_done),     32'd0);
    check({tag, "_data_done"},  32'(data_done),     32'd0);
    check({tag, "_inst_rdata"}, inst_rdata,         32'd0);
    check({tag, "_data_rdata"}, data_rdata,         32'd0);
    check({tag, "_stall_inst"}, 32'(stallreq_inst), 32'd0);
    check({tag, "_stall_data"}, 32'(stallreq_data), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) seq[i] = 1'b0;

    do_reset();
    settle();
    check_reset_values("reset");

    // ---- single zero-wait load ----
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h0000_1000;
    settle();
    check("ld_c0_stall", 32'(stallreq_data), 32'd1);
    check("ld_c0_mem_req", 32'(mem_req), 32'd0);
    tick(); mem_drive(1'b1, 1'b0, 32'd0); settle();
    check("ld_c1_mem_req", 32'(mem_req), 32'd1);
    check("ld_c1_mem_wr", 32'(mem_wr), 32'd0);
    check("ld_c1_wstrb", 32'(mem_wstrb), 32'hF);
    check("ld_c1_addr", mem_addr, 32'h0000_1000);
    check("ld_c1_stall", 32'(stallreq_data), 32'd1);
    tick(); mem_drive(1'b0, 1'b1, 32'hDEAD_BEEF); settle();
    check("ld_c2_mem_req", 32'(mem_req), 32'd0);
    check("ld_c2_done", 32'(data_done), 32'd0);
    check("ld_c2_stall", 32'(stallreq_data), 32'd1);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("ld_c3_done", 32'(data_done), 32'd1);
    check("ld_c3_rdata", data_rdata, 32'hDEAD_BEEF);
    check("ld_c3_stall", 32'(stallreq_data), 32'd0);
    check("ld_c3_inst_done", 32'(inst_done), 32'd0);
    tick(); data_req = 1'b0; settle();
    check("ld_c4_done", 32'(data_done), 32'd0);

    // ---- store with one byte enable ----
    tick();
    data_req   = 1'b1;
    data_wen   = 4'b0010;
    data_wdata = 32'h0000_AB00;
    data_addr  = 32'h0000_1004;
    settle();
    tick(); mem_drive(1'b1, 1'b0, 32'd0); settle();
    check("st_mem_req", 32'(mem_req), 32'd1);
    check("st_mem_wr", 32'(mem_wr), 32'd1);
    check("st_wstrb", 32'(mem_wstrb), 32'h2);
    check("st_wdata", mem_wdata, 32'h0000_AB00);
    check("st_addr", mem_addr, 32'h0000_1004);
    tick(); mem_drive(1'b0, 1'b1, 32'h1234_5678); settle();
    check("st_wait_wr", 32'(mem_wr), 32'd1);
    check("st_wait_wdata", mem_wdata, 32'h0000_AB00);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("st_done", 32'(data_done), 32'd1);
    check("st_rdata_kept", data_rdata, 32'hDEAD_BEEF);
    tick(); data_req = 1'b0; data_wen = 4'd0; settle();
    check("st_done_drop", 32'(data_done), 32'd0);

    // ---- fetch with addr_ok 3 late and data_ok 2 more late ----
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0040;
    settle();
    req_cycles  = 0;
    done_cycles = 0;
    done_at     = -1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      mem_drive(k == 4, k == 7, (k == 7) ? 32'hCAFE_F00D : 32'd0);
      if (k == 9) inst_req = 1'b0;
      settle();
      if (mem_req) req_cycles++;
      if (inst_done) begin
        done_cycles++;
        done_at = k;
        check("slow_rdata", inst_rdata, 32'hCAFE_F00D);
      end
      if (k <= 8) begin
        check("slow_addr_stable", mem_addr, 32'h0000_0040);
        check("slow_wstrb_stable", 32'(mem_wstrb), 32'hF);
      end
      check("slow_no_data_done", 32'(data_done), 32'd0);
    end
    check("slow_req_cycles", 32'(req_cycles), 32'd4);
    check("slow_done_count", 32'(done_cycles), 32'd1);
    check("slow_done_cycle", 32'(done_at), 32'd8);

    // ---- same-cycle addr_ok + data_ok, then a stray response in IDLE ----
    tick();
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h0000_2000;
    settle();
    tick(); mem_drive(1'b1, 1'b1, 32'h0BAD_C0DE); settle();
    check("fast_mem_req", 32'(mem_req), 32'd1);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("fast_done", 32'(data_done), 32'd1);
    check("fast_rdata", data_rdata, 32'h0BAD_C0DE);
    tick(); data_req = 1'b0; mem_drive(1'b1, 1'b1, 32'hFFFF_FFFF); settle();
    check("stray_c0_mem_req", 32'(mem_req), 32'd0);
    check("stray_c0_done", 32'(data_done), 32'd0);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("stray_data_done", 32'(data_done), 32'd0);
    check("stray_inst_done", 32'(inst_done), 32'd0);
    check("stray_mem_req", 32'(mem_req), 32'd0);
    check("stray_rdata_kept", data_rdata, 32'h0BAD_C0DE);

    // ---- reset while in WAIT ----
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0080;
    settle();
    tick(); mem_drive(1'b1, 1'b0, 32'd0); settle();
    check("rw_mem_req", 32'(mem_req), 32'd1);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); rst = 1'b1; inst_req = 1'b0; settle();
    check("rw_wait_mem_req", 32'(mem_req), 32'd0);
    tick(); rst = 1'b0; mem_drive(1'b0, 1'b1, 32'h55AA_55AA); settle();
    check_reset_values("rw_after");
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("rw_late_inst_done", 32'(inst_done), 32'd0);
    check("rw_late_inst_rdata", inst_rdata, 32'd0);
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0084;
    settle();
    tick(); mem_drive(1'b1, 1'b0, 32'd0); settle();
    check("rw_new_mem_req", 32'(mem_req), 32'd1);
    check("rw_new_addr", mem_addr, 32'h0000_0084);
    tick(); mem_drive(1'b0, 1'b1, 32'h1111_2222); settle();
    check("rw_new_wait_done", 32'(inst_done), 32'd0);
    tick(); mem_drive(1'b0, 1'b0, 32'd0); settle();
    check("rw_new_done", 32'(inst_done), 32'd1);
    check("rw_new_rdata", inst_rdata, 32'h1111_2222);
    check("rw_new_stall", 32'(stallreq_inst), 32'd0);
    tick(); inst_req = 1'b0; settle();

    // ---- both requesters held, zero-wait memory, STARVE_MAX = 4 ----
    do_reset();
    inst_addr = 32'h0000_0100;
    data_addr = 32'h0000_3000;
    data_wen  = 4'd0;
    inst_req  = 1'b1;
    data_req  = 1'b1;
    mem_auto();
    settle();
    n_done = 0;
    for (int c = 0; c < 100 && n_done < 10; c++) begin
      tick();
      mem_auto();
      settle();
      if (inst_done || data_done) begin
        check("arb_done_exclusive", 32'(inst_done & data_done), 32'd0);
        if (inst_done) begin
          check("arb_inst_rdata", inst_rdata, mem_word(inst_addr));
          check("arb_stall_inst", 32'(stallreq_inst), 32'd0);
          seq[n_done] = 1'b1;
          inst_addr   = inst_addr + 32'd4;
        end else begin
          check("arb_data_rdata", data_rdata, mem_word(data_addr));
          check("arb_stall_data", 32'(stallreq_data), 32'd0);
          seq[n_done] = 1'b0;
          data_addr   = data_addr + 32'd4;
        end
        n_done++;
      end
    end
    check("arb_count", 32'(n_done), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("arb_order_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();

    // ---- report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
